// File: rtl/mining_result_reporter_pkg.sv
// Shared definitions for the mining result reporter: frame layout constants,
// entry type bit positions, FSM state type and frame helper functions.
package mining_result_reporter_pkg;

  localparam int unsigned DATA_WID_DEF     = 32;
  localparam logic [7:0]  FRAME_HEADER_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN        = 11;

  localparam int unsigned TYPE_WID      = 2;
  localparam int unsigned TYPE_VLD_BIT  = 0;
  localparam int unsigned TYPE_FULL_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Queue entry layout: {type, extranounce2, nonce}.
  function automatic int unsigned entry_wid(input int unsigned data_wid);
    return TYPE_WID + 2 * data_wid;
  endfunction

  // XOR of frame bytes 1..9.
  function automatic logic [7:0] frame_checksum(input logic [1:0]  typ,
                                                input logic [31:0] en2,
                                                input logic [31:0] nonce);
    logic [7:0] sum;
    sum = {6'b0, typ};
    for (int unsigned i = 0; i < 4; i++) begin
      sum = sum ^ en2[8*i +: 8] ^ nonce[8*i +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/mining_result_reporter_if.sv
// Event queue bus between the reporter and its FIFO.
//   push/pop/wdata : driven by the master (reporter)
//   rdata          : head entry, valid while !empty
//   empty/full/count : queue occupancy, driven by the slave (FIFO)
interface mining_result_reporter_if #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport master (
    output push, pop, wdata,
    input  rdata, empty, full, count
  );

  modport slave (
    input  push, pop, wdata,
    output rdata, empty, full, count
  );

endinterface

// File: rtl/mining_result_reporter_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read.
//   clk, rst : clock and synchronous active-high reset (flushes the queue)
//   bus      : slave side of the event queue bus
// A push while full is taken only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  mining_result_reporter_if.slave   bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign bus.empty = (count == '0);
  assign bus.full  = (count == CNT_W'(DEPTH));
  assign bus.count = count;
  assign bus.rdata = mem[rd_ptr];

  assign do_pop  = bus.pop & ~bus.empty;
  assign do_push = bus.push & (~bus.full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.wdata;
  end

endmodule

// File: rtl/mining_result_reporter.sv
// Queues mining result events and serialises each into an 11-byte frame
// on a byte-wide valid/ready stream.
//   clk, rst                     : clock, synchronous active-high reset
//   iv_mining_extranounce2       : extranounce2 of the event
//   iv_mining_nounce             : nonce of the event
//   i_mining_nounce_vld/_full    : event pulses (winning nonce / space exhausted)
//   ov_tx_data, o_tx_vld, i_tx_rdy : frame byte stream
//   ov_drop_cnt                  : saturating count of events lost to a full queue
//   o_fifo_empty                 : event queue is empty
module mining_result_reporter
  import mining_result_reporter_pkg::*;
#(
  parameter int unsigned DATA_WID      = DATA_WID_DEF,
  parameter int unsigned UART_DATA_WID = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter logic [7:0]  FRAME_HEADER  = FRAME_HEADER_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WID-1:0]      iv_mining_extranounce2,
  input  logic [DATA_WID-1:0]      iv_mining_nounce,
  input  logic                     i_mining_nounce_vld,
  input  logic                     i_mining_nounce_full,
  output logic [UART_DATA_WID-1:0] ov_tx_data,
  output logic                     o_tx_vld,
  input  logic                     i_tx_rdy,
  output logic [15:0]              ov_drop_cnt,
  output logic                     o_fifo_empty
);

  localparam int unsigned EW       = entry_wid(DATA_WID);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  mining_result_reporter_if #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) fifo_bus ();

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk (clk),
    .rst (rst),
    .bus (fifo_bus)
  );

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                pop;
  logic                ev_push;
  logic                drop;
  logic [TYPE_WID-1:0] ev_type;
  logic [TYPE_WID-1:0] frm_type;
  logic [DATA_WID-1:0] frm_en2;
  logic [DATA_WID-1:0] frm_nonce;
  logic [7:0]          frm_csum;
  logic [7:0]          tx_byte;
  logic [TYPE_WID-1:0] head_type;
  logic [DATA_WID-1:0] head_en2;
  logic [DATA_WID-1:0] head_nonce;

  always_comb begin
    ev_type                = '0;
    ev_type[TYPE_VLD_BIT]  = i_mining_nounce_vld;
    ev_type[TYPE_FULL_BIT] = i_mining_nounce_full;
  end

  assign ev_push = (i_mining_nounce_vld | i_mining_nounce_full) & ~rst;
  assign drop    = ev_push & (fifo_bus.count == CNT_W'(FIFO_DEPTH)) & ~pop;

  assign fifo_bus.push  = ev_push;
  assign fifo_bus.pop   = pop;
  assign fifo_bus.wdata = {ev_type, iv_mining_extranounce2, iv_mining_nounce};

  assign head_type  = fifo_bus.rdata[EW-1 -: TYPE_WID];
  assign head_en2   = fifo_bus.rdata[2*DATA_WID-1 -: DATA_WID];
  assign head_nonce = fifo_bus.rdata[DATA_WID-1:0];

  assign o_fifo_empty = fifo_bus.empty;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_bus.empty) begin
          pop       = 1'b1;
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (i_tx_rdy) begin
          if (idx == IDX_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      frm_type  <= '0;
      frm_en2   <= '0;
      frm_nonce <= '0;
      frm_csum  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (pop) begin
        frm_type  <= head_type;
        frm_en2   <= head_en2;
        frm_nonce <= head_nonce;
        frm_csum  <= frame_checksum(head_type, head_en2, head_nonce);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_drop_cnt <= '0;
    end else if (drop && ov_drop_cnt != '1) begin
      ov_drop_cnt <= ov_drop_cnt + 16'd1;
    end
  end

  always_comb begin
    tx_byte = '0;
    case (idx)
      4'd0:    tx_byte = FRAME_HEADER;
      4'd1:    tx_byte = {6'b0, frm_type};
      4'd2:    tx_byte = frm_en2[31:24];
      4'd3:    tx_byte = frm_en2[23:16];
      4'd4:    tx_byte = frm_en2[15:8];
      4'd5:    tx_byte = frm_en2[7:0];
      4'd6:    tx_byte = frm_nonce[31:24];
      4'd7:    tx_byte = frm_nonce[23:16];
      4'd8:    tx_byte = frm_nonce[15:8];
      4'd9:    tx_byte = frm_nonce[7:0];
      4'd10:   tx_byte = frm_csum;
      default: tx_byte = '0;
    endcase
  end

  assign o_tx_vld   = (state == SEND);
  assign ov_tx_data = o_tx_vld ? UART_DATA_WID'(tx_byte) : '0;

endmodule
